jtframe_bank_slots: RTL and testbench



---
 rtl/jtframe_bank_slots_pkg.sv | 16 +
 rtl/jtframe_slot_rr.sv | 32 +++
 rtl/jtframe_bank_slots.sv | 131 +++++++++++++
 tb/tb_jtframe_bank_slots.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_bank_slots_pkg.sv
// Shared definitions for the multi-slot SDRAM bank read arbiter.
// FSM encoding and slot-index width helper.
package jtframe_bank_slots_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_WAIT_RDY = 2'd2;

    // Width of a slot index; at least one bit so a 1-slot build still elaborates.
    function automatic int unsigned slot_iw(input int unsigned slots);
        int unsigned w;
        w = 32'($clog2(slots));
        return (w == 0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/jtframe_slot_rr.sv
// Next-winner selection for multi-slot arbiters: round-robin from ptr
// when RR is set, otherwise lowest index wins.
module jtframe_slot_rr
    import jtframe_bank_slots_pkg::*;
#(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned RR    = 1,
    localparam int unsigned SW   = slot_iw(SLOTS)
)(
    input  logic [SLOTS-1:0] miss,
    input  logic [SW-1:0]    ptr,
    output logic [SW-1:0]    grant_c,
    output logic             any_req_c
);

    always_comb begin
        int unsigned idx;
        logic [SW-1:0] idx_s;
        grant_c   = '0;
        any_req_c = 1'b0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            idx = (RR != 0) ? 32'(ptr) + k : k;
            if (idx >= SLOTS) idx = idx - SLOTS;
            idx_s = SW'(idx);
            if (!any_req_c && miss[idx_s]) begin
                grant_c   = idx_s;
                any_req_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_bank_slots.sv
// N-slot read arbiter with one-word cache per slot, sharing one SDRAM bank
// read port. Slot OK is combinational against the registered tag.
module jtframe_bank_slots
    import jtframe_bank_slots_pkg::*;
#(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned AW    = 22,
    parameter int unsigned DW    = 16,
    parameter int unsigned RR    = 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic [AW-1:0]       ba_addr,
    output logic                ba_rd,
    input  logic                ba_ack,
    input  logic                ba_rdy,
    input  logic [DW-1:0]       data_read
);

    localparam int unsigned SW = slot_iw(SLOTS);

    logic [1:0]                st, st_nx;
    logic                      ba_rd_nx;
    logic [AW-1:0]             ba_addr_nx;
    logic [SW-1:0]             sel, sel_nx, ptr, ptr_nx, grant_c;
    logic                      discard, discard_nx, any_req_c, fill_c;
    logic [SLOTS-1:0]          valid, valid_nx, miss_c;
    logic [SLOTS-1:0][AW-1:0]  tag, addr_c;
    logic [SLOTS-1:0][DW-1:0]  data;

    assign addr_c    = slot_addr;
    assign slot_dout = data;
    assign miss_c    = slot_cs & ~slot_ok;

    // Hit detection against the tag of the last completed fill
    always_comb begin
        slot_ok = '0;
        for (int unsigned i = 0; i < SLOTS; i++)
            slot_ok[i] = slot_cs[i] & valid[i] & (addr_c[i] == tag[i]);
    end

    jtframe_slot_rr #(
        .SLOTS (SLOTS),
        .RR    (RR)
    ) u_rr (
        .miss      (miss_c),
        .ptr       (ptr),
        .grant_c   (grant_c),
        .any_req_c (any_req_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        st_nx      = st;
        ba_rd_nx   = ba_rd;
        ba_addr_nx = ba_addr;
        sel_nx     = sel;
        ptr_nx     = ptr;
        discard_nx = discard | flush;
        fill_c     = 1'b0;
        case (st)
            ST_IDLE: begin
                discard_nx = 1'b0;
                if (any_req_c && !flush) begin
                    ba_addr_nx = addr_c[grant_c];
                    sel_nx     = grant_c;
                    ba_rd_nx   = 1'b1;
                    st_nx      = ST_WAIT_ACK;
                    if (RR != 0)
                        ptr_nx = (grant_c == SW'(SLOTS-1)) ? '0 : grant_c + SW'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (ba_ack) begin
                    ba_rd_nx = 1'b0;
                    if (ba_rdy) begin
                        fill_c = 1'b1;
                        st_nx  = ST_IDLE;
                    end else begin
                        st_nx  = ST_WAIT_RDY;
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (ba_rdy) begin
                    fill_c = 1'b1;
                    st_nx  = ST_IDLE;
                end
            end
            default: begin
                st_nx    = ST_IDLE;
                ba_rd_nx = 1'b0;
            end
        endcase
        // A flush landing on the fill cycle also discards that fill
        valid_nx = flush ? '0 : valid;
        if (fill_c) valid_nx[sel] = ~(discard | flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= ST_IDLE;
            ba_rd   <= 1'b0;
            ba_addr <= '0;
            sel     <= '0;
            ptr     <= '0;
            discard <= 1'b0;
            valid   <= '0;
            tag     <= '0;
            data    <= '0;
        end else begin
            st      <= st_nx;
            ba_rd   <= ba_rd_nx;
            ba_addr <= ba_addr_nx;
            sel     <= sel_nx;
            ptr     <= ptr_nx;
            discard <= discard_nx;
            valid   <= valid_nx;
            if (fill_c) begin
                tag[sel]  <= ba_addr;
                data[sel] <= data_read;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_bank_slots.sv
// Scoreboard bench for jtframe_bank_slots: one round-robin and one
// fixed-priority instance, each with its own modelled SDRAM controller.
module tb_jtframe_bank_slots;

    localparam int unsigned SLOTS = 4;
    localparam int unsigned AW    = 22;
    localparam int unsigned DW    = 16;

    typedef struct {
        int unsigned   slot;
        logic [AW-1:0] addr;
        logic          ok;
        logic [DW-1:0] data;
    } sb_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic [SLOTS-1:0]    slot_cs   [2];
    logic [SLOTS*AW-1:0] slot_addr [2];
    logic [SLOTS-1:0]    slot_ok   [2];
    logic [SLOTS*DW-1:0] slot_dout [2];
    logic [AW-1:0]       ba_addr   [2];
    logic                ba_rd     [2];
    logic                ba_ack    [2];
    logic                ba_rdy    [2];
    logic [DW-1:0]       data_read [2];

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    jtframe_bank_slots #(.SLOTS(SLOTS), .AW(AW), .DW(DW), .RR(1)) u_rr (
        .clk(clk), .rst(rst), .flush(flush),
        .slot_cs(slot_cs[0]), .slot_addr(slot_addr[0]),
        .slot_ok(slot_ok[0]), .slot_dout(slot_dout[0]),
        .ba_addr(ba_addr[0]), .ba_rd(ba_rd[0]),
        .ba_ack(ba_ack[0]), .ba_rdy(ba_rdy[0]), .data_read(data_read[0])
    );

    jtframe_bank_slots #(.SLOTS(SLOTS), .AW(AW), .DW(DW), .RR(0)) u_fp (
        .clk(clk), .rst(rst), .flush(flush),
        .slot_cs(slot_cs[1]), .slot_addr(slot_addr[1]),
        .slot_ok(slot_ok[1]), .slot_dout(slot_dout[1]),
        .ba_addr(ba_addr[1]), .ba_rd(ba_rd[1]),
        .ba_ack(ba_ack[1]), .ba_rdy(ba_rdy[1]), .data_read(data_read[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
        return DW'(a) ^ 16'hC3C3;
    endfunction

    task automatic set_addr(input int m, input int s, input logic [AW-1:0] a);
        slot_addr[m][s*AW +: AW] = a;
    endtask

    task automatic push(input int unsigned s, input logic [AW-1:0] a, input logic ok,
                        input logic [DW-1:0] d);
        sb_t e;
        e.slot = s; e.addr = a; e.ok = ok; e.data = d;
        sb.push_back(e);
    endtask

    // Controller model: wait for a request, check it against the scoreboard,
    // then ack after ack_dly cycles and deliver data rdy_dly cycles after ack.
    task automatic serve(input int m, input int ack_dly, input int rdy_dly);
        sb_t e;
        int  n;
        n = 0;
        while (!ba_rd[m] && n < 20) begin
            tick();
            n++;
        end
        if (!ba_rd[m]) begin
            check("rd_timeout", 32'(ba_rd[m]), 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check("ba_addr", 32'(ba_addr[m]), 32'(e.addr));
        repeat (ack_dly) begin
            tick();
            check("rd_hold", 32'(ba_rd[m]), 32'd1);
            check("addr_hold", 32'(ba_addr[m]), 32'(e.addr));
        end
        ba_ack[m] = 1'b1;
        if (rdy_dly == 0) begin
            ba_rdy[m]    = 1'b1;
            data_read[m] = e.data;
        end
        tick();
        ba_ack[m] = 1'b0;
        ba_rdy[m] = 1'b0;
        if (rdy_dly > 0) begin
            check("rd_drop", 32'(ba_rd[m]), 32'd0);
            repeat (rdy_dly - 1) tick();
            ba_rdy[m]    = 1'b1;
            data_read[m] = e.data;
            tick();
            ba_rdy[m] = 1'b0;
        end
        check($sformatf("ok%0d", e.slot), 32'(slot_ok[m][e.slot]), 32'(e.ok));
        check($sformatf("dout%0d", e.slot), 32'(slot_dout[m][e.slot*DW +: DW]), 32'(e.data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        for (int m = 0; m < 2; m++) begin
            slot_cs[m] = '0; slot_addr[m] = '0;
            ba_ack[m] = 1'b0; ba_rdy[m] = 1'b0; data_read[m] = '0;
        end
        tick(); tick();
        rst = 1'b0;

        // reset state
        for (int m = 0; m < 2; m++) begin
            check("rst_ok", 32'(slot_ok[m]), 32'd0);
            check("rst_rd", 32'(ba_rd[m]), 32'd0);
            check("rst_addr", 32'(ba_addr[m]), 32'd0);
            check("rst_dout", slot_dout[m][31:0], 32'd0);
        end

        // cold read
        slot_cs[0] = 4'b0001;
        set_addr(0, 0, 22'h000100);
        push(0, 22'h000100, 1'b1, 16'hA55A);
        tick();
        check("rd_lat", 32'(ba_rd[0]), 32'd1);
        serve(0, 2, 4);

        // hit then address change
        set_addr(0, 0, 22'h000101);
        #1;
        check("ok_drop", 32'(slot_ok[0][0]), 32'd0);
        push(0, 22'h000101, 1'b1, dat(22'h000101));
        serve(0, 1, 1);
        set_addr(0, 0, 22'h000100);
        #1;
        check("old_tag", 32'(slot_ok[0][0]), 32'd0);
        push(0, 22'h000100, 1'b1, dat(22'h000100));
        serve(0, 0, 2);

        // round-robin fairness from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        slot_cs[0] = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            set_addr(0, s, 22'h000200 + AW'(s));
            push(32'(s), 22'h000200 + AW'(s), 1'b1, dat(22'h000200 + AW'(s)));
        end
        for (int s = 0; s < 4; s++) serve(0, 0, 0);
        for (int s = 0; s < 4; s++) begin
            if (s != 2) begin
                set_addr(0, s, 22'h000300 + AW'(s));
                push(32'(s), 22'h000300 + AW'(s), 1'b1, dat(22'h000300 + AW'(s)));
            end
        end
        for (int s = 0; s < 3; s++) serve(0, 0, 0);

        // fixed priority: slot1 keeps missing, slot2 starves
        slot_cs[1] = 4'b0110;
        a = 22'h000400;
        set_addr(1, 1, a);
        set_addr(1, 2, 22'h000500);
        for (int r = 0; r < 3; r++) begin
            push(1, a, 1'b1, dat(a));
            serve(1, 0, 0);
            check("starve2", 32'(slot_ok[1][2]), 32'd0);
            if (r < 2) begin
                a = a ^ 22'h1;
                set_addr(1, 1, a);
            end
        end
        slot_cs[1] = 4'b0000;
        tick(); tick();
        check("cs0_norq", 32'(ba_rd[1]), 32'd0);
        slot_cs[1] = 4'b0010;
        #1;
        check("kept_ok", 32'(slot_ok[1][1]), 32'd1);
        tick();
        check("kept_norq", 32'(ba_rd[1]), 32'd0);
        slot_cs[1] = 4'b0000;

        // flush while slot2's read waits for data
        set_addr(0, 2, 22'h000602);
        tick();
        check("fl_rd", 32'(ba_rd[0]), 32'd1);
        check("fl_addr", 32'(ba_addr[0]), 32'h602);
        ba_ack[0] = 1'b1;
        tick();
        ba_ack[0] = 1'b0;
        flush = 1'b1;
        tick();
        check("fl_okall", 32'(slot_ok[0]), 32'd0);
        flush = 1'b0;
        check("fl_norq", 32'(ba_rd[0]), 32'd0);
        ba_rdy[0] = 1'b1;
        data_read[0] = 16'hBEEF;
        tick();
        ba_rdy[0] = 1'b0;
        check("fl_ok2", 32'(slot_ok[0][2]), 32'd0);
        check("fl_norq2", 32'(ba_rd[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            int s;
            s = (k + 3) % 4;
            a = (s == 2) ? 22'h000602 : 22'h000300 + AW'(s);
            push(32'(s), a, 1'b1, dat(a) ^ 16'h0F0F);
        end
        for (int k = 0; k < 4; k++) serve(0, 0, 1);

        // flush held in IDLE blocks new requests
        flush = 1'b1;
        tick();
        check("fi_ok", 32'(slot_ok[0]), 32'd0);
        tick(); tick();
        check("fi_norq", 32'(ba_rd[0]), 32'd0);
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int s;
            s = (k + 3) % 4;
            a = (s == 2) ? 22'h000602 : 22'h000300 + AW'(s);
            push(32'(s), a, 1'b1, dat(a) ^ 16'h7777);
        end
        for (int k = 0; k < 4; k++) serve(0, 1, 0);

        // reset during WAIT_ACK, then a stray rdy
        set_addr(0, 0, 22'h000700);
        tick();
        check("ra_rd", 32'(ba_rd[0]), 32'd1);
        rst = 1'b1;
        slot_cs[0] = 4'b0000;
        tick();
        rst = 1'b0;
        check("ra_rd0", 32'(ba_rd[0]), 32'd0);
        check("ra_ok", 32'(slot_ok[0]), 32'd0);
        ba_rdy[0] = 1'b1;
        data_read[0] = 16'hFFFF;
        tick();
        ba_rdy[0] = 1'b0;
        check("ra_dout", slot_dout[0][31:0], 32'd0);
        check("ra_douth", slot_dout[0][63:32], 32'd0);
        check("ra_norq", 32'(ba_rd[0]), 32'd0);
        slot_cs[0] = 4'b1111;
        #1;
        check("ra_okcs", 32'(slot_ok[0]), 32'd0);
        slot_cs[0] = 4'b0000;

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
